// File: rtl/char_write_arbiter.sv
// Two-requester character write arbiter feeding a character feeder, with scroll/clear hold-off.
// Optional printable-code filter enabled by defining CHARARB_FILTER_EN.
module char_write_arbiter #(
  parameter int unsigned SCROLL_WAIT = 40,
  parameter int unsigned CLEAR_WAIT  = 600
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       a_valid,
  input  logic [7:0] a_char,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_char,
  output logic       b_ready,
  output logic [7:0] feed_char,
  output logic       feed_we,
  input  logic       push_up,
  input  logic       reset_call,
  output logic       busy,
  output logic       last_grant,
  output logic       dropped
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    SCROLL_HOLD,
    CLEAR_HOLD
  } state_t;

  localparam logic [9:0] SCROLL_LOAD = 10'((SCROLL_WAIT == 0) ? 0 : SCROLL_WAIT - 1);
  localparam logic [9:0] CLEAR_LOAD  = 10'((CLEAR_WAIT == 0) ? 0 : CLEAR_WAIT - 1);

  state_t     state, state_nxt;
  logic [9:0] cnt;
  logic       grant_a, grant_b, xfer, keep;
  logic [7:0] sel_char;

  // Round-robin: on contention the requester that did not win last time is served.
  assign grant_a  = a_valid & (~b_valid | last_grant);
  assign grant_b  = b_valid & (~a_valid | ~last_grant);
  assign a_ready  = reset_n & (state == IDLE) & grant_a;
  assign b_ready  = reset_n & (state == IDLE) & grant_b;
  assign xfer     = a_ready | b_ready;
  assign sel_char = grant_a ? a_char : b_char;
  assign busy     = (state != IDLE);

`ifdef CHARARB_FILTER_EN
  function automatic logic code_ok(input logic [7:0] c);
    return ((c >= 8'd48)  && (c <= 8'd57))  ||
           ((c >= 8'd65)  && (c <= 8'd90))  ||
           ((c >= 8'd97)  && (c <= 8'd122)) ||
           ((c >= 8'd128) && (c <= 8'd195)) ||
           (c == 8'd255);
  endfunction
  assign keep = code_ok(sel_char);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (xfer) state_nxt = keep ? ISSUE : SETTLE;
      ISSUE:  state_nxt = SETTLE;
      // A dropped code passes through SETTLE without a feed_we, so flags are not sampled.
      SETTLE: begin
        if (dropped)
          state_nxt = IDLE;
        else if (reset_call)
          state_nxt = (CLEAR_WAIT == 0) ? IDLE : CLEAR_HOLD;
        else if (push_up)
          state_nxt = (SCROLL_WAIT == 0) ? IDLE : SCROLL_HOLD;
        else
          state_nxt = IDLE;
      end
      SCROLL_HOLD, CLEAR_HOLD: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      feed_char  <= '0;
      feed_we    <= 1'b0;
      dropped    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state   <= state_nxt;
      feed_we <= xfer & keep;
      dropped <= xfer & ~keep;
      if (xfer) last_grant <= b_ready;
      if (xfer && keep) feed_char <= sel_char;
      if (state == SETTLE && state_nxt == CLEAR_HOLD)
        cnt <= CLEAR_LOAD;
      else if (state == SETTLE && state_nxt == SCROLL_HOLD)
        cnt <= SCROLL_LOAD;
      else if ((state == SCROLL_HOLD || state == CLEAR_HOLD) && cnt != '0)
        cnt <= cnt - 10'd1;
    end
  end

endmodule

// File: tb/tb_char_write_arbiter.sv
// Directed bench for char_write_arbiter: arbitration, issue timing, hold-offs, reset and filter.
module tb_char_write_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_char, b_char, feed_char;
  logic       feed_we, push_up, reset_call, busy, last_grant, dropped;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  char_write_arbiter #(.SCROLL_WAIT(40), .CLEAR_WAIT(600)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_char(a_char), .a_ready(a_ready),
    .b_valid(b_valid), .b_char(b_char), .b_ready(b_ready),
    .feed_char(feed_char), .feed_we(feed_we),
    .push_up(push_up), .reset_call(reset_call),
    .busy(busy), .last_grant(last_grant), .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned gap;
    int unsigned errs;
    logic [7:0] seq [4];
    seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h31; seq[3] = 8'h32;

    reset_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; a_char = '0; b_char = '0;
    push_up = 1'b0; reset_call = 1'b0;
    tick(); tick();
    check("rst_feed_we", feed_we, 0);
    check("rst_feed_char", feed_char, 0);
    check("rst_dropped", dropped, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 0);
    a_valid = 1'b0;
    reset_n = 1'b1;

    // Single A request
    tick();
    a_valid = 1'b1; a_char = 8'h41; #1;
    check("single_a_ready", a_ready, 1);
    check("single_b_ready", b_ready, 0);
    tick(); a_valid = 1'b0;
    check("single_issue_we", feed_we, 1);
    check("single_issue_char", feed_char, 8'h41);
    check("single_issue_busy", busy, 1);
    check("single_last_grant", last_grant, 0);
    check("single_issue_ready", a_ready, 0);
    tick();
    check("single_settle_we", feed_we, 0);
    check("single_settle_char", feed_char, 8'h41);
    check("single_settle_busy", busy, 1);
    tick();
    check("single_idle_busy", busy, 0);

    // Alternation out of reset
    reset_n = 1'b0; #1; reset_n = 1'b1;
    a_valid = 1'b1; a_char = 8'h31; b_valid = 1'b1; b_char = 8'h32; #1;
    check("alt_first_a_ready", a_ready, 1);
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin tick(); gap++; end while (!feed_we && gap < 10);
      check("alt_we", feed_we, 1);
      check("alt_char", feed_char, seq[k]);
      if (k > 0) check("alt_gap", gap, 3);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
    check("alt_idle", busy, 0);

    // Scroll hold (push_up already high during ISSUE, which must be ignored there)
    a_valid = 1'b1; a_char = 8'h42;
    tick(); a_valid = 1'b0; push_up = 1'b1;
    check("scroll_issue_char", feed_char, 8'h42);
    tick();
    b_valid = 1'b1; b_char = 8'hFF; #1;
    check("scroll_settle_b_ready", b_ready, 0);
    tick(); push_up = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("scroll_busy", busy, 1);
      check("scroll_b_ready", b_ready, 0);
      tick();
    end
    check("scroll_done_busy", busy, 0);
    check("scroll_done_b_ready", b_ready, 1);

    // Clear hold with A waiting; B wins since A was granted last
    a_valid = 1'b1; a_char = 8'h43; #1;
    check("clear_b_ready", b_ready, 1);
    check("clear_a_ready", a_ready, 0);
    tick(); b_valid = 1'b0; reset_call = 1'b1; push_up = 1'b1;
    check("clear_issue_we", feed_we, 1);
    check("clear_issue_char", feed_char, 8'hFF);
    check("clear_last_grant", last_grant, 1);
    tick();
    check("clear_settle_a_ready", a_ready, 0);
    tick(); reset_call = 1'b0; push_up = 1'b0;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy !== 1'b1 || a_ready !== 1'b0) errs++;
      tick();
    end
    check("clear_hold_cycles", errs, 0);
    check("clear_done_busy", busy, 0);
    check("clear_done_a_ready", a_ready, 1);
    tick(); a_valid = 1'b0;
    check("clear_a_issue_we", feed_we, 1);
    check("clear_a_issue_char", feed_char, 8'h43);
    tick(); tick();

    // Reset during a scroll hold
    a_valid = 1'b1; a_char = 8'h44; push_up = 1'b1;
    tick(); a_valid = 1'b0;
    tick(); tick(); push_up = 1'b0;
    tick(); tick();
    check("hold_busy_before_rst", busy, 1);
    reset_n = 1'b0; a_valid = 1'b1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_feed_we", feed_we, 0);
    check("mid_rst_feed_char", feed_char, 0);
    check("mid_rst_last_grant", last_grant, 1);
    check("mid_rst_dropped", dropped, 0);
    check("mid_rst_a_ready", a_ready, 0);
    tick();
    reset_n = 1'b1; a_char = 8'h45; b_valid = 1'b1; b_char = 8'h46; #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);
    tick(); a_valid = 1'b0; b_valid = 1'b0;
    check("post_rst_we", feed_we, 1);
    check("post_rst_char", feed_char, 8'h45);
    tick(); tick();

    // Non-printable code
    a_valid = 1'b1; a_char = 8'h0A; #1;
    check("ctl_a_ready", a_ready, 1);
    tick(); a_valid = 1'b0;
`ifdef CHARARB_FILTER_EN
    check("ctl_drop_we", feed_we, 0);
    check("ctl_drop_pulse", dropped, 1);
    check("ctl_drop_char_held", feed_char, 8'h45);
    check("ctl_drop_busy", busy, 1);
    tick();
    check("ctl_drop_idle", busy, 0);
    check("ctl_drop_pulse_end", dropped, 0);
    check("ctl_drop_no_we", feed_we, 0);
`else
    check("ctl_issue_we", feed_we, 1);
    check("ctl_issue_char", feed_char, 8'h0A);
    check("ctl_no_drop", dropped, 0);
    tick(); tick();
    check("ctl_idle", busy, 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
